// File: rtl/prover_mlext_fold.sv
// Prover-side multilinear-extension evaluator: folds a 2^nValBits table of field values one tau
// coordinate per round, in place, until a single value (the MLE at tau) remains.
module prover_mlext_fold #(
    parameter int unsigned         nValBits = 4,
    parameter int unsigned         F_NBITS  = 61,
    parameter logic [F_NBITS-1:0]  F_Q      = {F_NBITS{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [F_NBITS-1:0] tau     [nValBits],
    input  logic [F_NBITS-1:0] vals_in [1 << nValBits],
    output logic [F_NBITS-1:0] mlext_out,
    output logic               ready
);

    localparam int unsigned NValues = 1 << nValBits;
    localparam int unsigned RW      = (nValBits > 1) ? $clog2(nValBits) : 1;
    localparam int unsigned DW      = 2 * F_NBITS;

    typedef enum logic [0:0] {StIdle, StFold} state_e;

    state_e               state_q, state_d;
    logic [RW-1:0]        r_q, r_d;
    logic [nValBits-1:0]  k_q, k_d;
    logic [F_NBITS-1:0]   mlext_q, mlext_d;

    logic [F_NBITS-1:0]   t_q [nValBits];
    logic [F_NBITS-1:0]   v_q [NValues];
    logic [F_NBITS-1:0]   v_d [NValues];

    logic                 load;
    logic                 fold_we;

    // Fold datapath: res = a + t * (b - a) mod F_Q, with a = V[2k], b = V[2k+1].
    logic [nValBits-1:0]  lo_idx, hi_idx, k_last;
    logic [F_NBITS-1:0]   op_a, op_b, t_cur, diff, prod_red, fold_res;
    logic [F_NBITS:0]     diff_sum, res_sum, q_ext;
    logic [DW-1:0]        prod;

    always_comb begin
        q_ext    = {1'b0, F_Q};
        lo_idx   = k_q << 1;
        hi_idx   = lo_idx | nValBits'(1);
        op_a     = v_q[lo_idx];
        op_b     = v_q[hi_idx];
        t_cur    = t_q[r_q];

        diff_sum = {1'b0, op_b} + {1'b0, F_Q - op_a};
        diff     = (diff_sum >= q_ext) ? F_NBITS'(diff_sum - q_ext) : F_NBITS'(diff_sum);

        prod     = DW'(t_cur) * DW'(diff);
        prod_red = F_NBITS'(prod % DW'(F_Q));

        res_sum  = {1'b0, op_a} + {1'b0, prod_red};
        fold_res = (res_sum >= q_ext) ? F_NBITS'(res_sum - q_ext) : F_NBITS'(res_sum);

        // Last k of round r is P-1 = 2^(nValBits-1-r) - 1.
        k_last   = {nValBits{1'b1}} >> r_q >> 1;
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        mlext_d = mlext_q;
        load    = 1'b0;
        fold_we = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    load    = 1'b1;
                    r_d     = '0;
                    k_d     = '0;
                    state_d = StFold;
                end
            end
            StFold: begin
                fold_we = 1'b1;
                if (k_q < k_last) begin
                    k_d = k_q + nValBits'(1);
                end else if (r_q < RW'(nValBits - 1)) begin
                    r_d = r_q + RW'(1);
                    k_d = '0;
                end else begin
                    mlext_d = fold_res;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Writing V[k] while reading V[2k], V[2k+1] is safe: later reads this round are at 2k+2 and up.
    always_comb begin
        v_d = v_q;
        if (load) begin
            v_d = vals_in;
        end else if (fold_we) begin
            v_d[k_q] = fold_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            k_q     <= '0;
            mlext_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            mlext_q <= mlext_d;
        end
    end

    // Operand buffers need no reset: they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (load) begin
            t_q <= tau;
        end
        v_q <= v_d;
    end

    assign mlext_out = mlext_q;
    assign ready     = (state_q == StIdle);

endmodule

// File: tb/tb_prover_mlext_fold.sv
// Scoreboard bench for prover_mlext_fold: a 4-bit and a 1-bit instance checked against a
// chi-vector dot-product reference model.
module tb_prover_mlext_fold;

    localparam int unsigned NB = 4;
    localparam int unsigned NV = 16;
    localparam int unsigned FN = 61;
    localparam logic [FN-1:0] Q = {FN{1'b1}};

    typedef struct {
        logic [FN-1:0] val;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en4 = 1'b0;
    logic          en1 = 1'b0;
    logic [FN-1:0] tau4  [NB];
    logic [FN-1:0] vals4 [NV];
    logic [FN-1:0] tau1  [1];
    logic [FN-1:0] vals1 [2];
    logic [FN-1:0] out4, out1;
    logic          rdy4, rdy1;

    exp_t q4[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev4 = 1'b1;
    logic prev1 = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prover_mlext_fold #(.nValBits(4), .F_NBITS(FN), .F_Q(Q)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .tau(tau4), .vals_in(vals4),
        .mlext_out(out4), .ready(rdy4)
    );

    prover_mlext_fold #(.nValBits(1), .F_NBITS(FN), .F_Q(Q)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .tau(tau1), .vals_in(vals1),
        .mlext_out(out1), .ready(rdy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [FN-1:0] mulmod(input logic [FN-1:0] a, input logic [FN-1:0] b);
        logic [127:0] p;
        p = 128'(a) * 128'(b);
        return FN'(p % 128'(Q));
    endfunction

    function automatic logic [FN-1:0] addmod(input logic [FN-1:0] a, input logic [FN-1:0] b);
        logic [63:0] s;
        s = 64'(a) + 64'(b);
        return FN'(s % 64'(Q));
    endfunction

    function automatic logic [FN-1:0] submod(input logic [FN-1:0] a, input logic [FN-1:0] b);
        return addmod(a, Q - b);
    endfunction

    // MLE(v, t) = sum_i v[i] * prod_j (bit j of i ? t[j] : 1 - t[j]).
    function automatic logic [FN-1:0] mle_ref(input logic [FN-1:0] t [NB],
                                              input logic [FN-1:0] v [NV], input int n);
        logic [FN-1:0] acc, chi;
        acc = '0;
        for (int i = 0; i < (1 << n); i++) begin
            chi = FN'(1);
            for (int j = 0; j < n; j++)
                chi = mulmod(chi, ((i >> j) & 1) != 0 ? t[j] : submod(FN'(1), t[j]));
            acc = addmod(acc, mulmod(v[i], chi));
        end
        return acc;
    endfunction

    function automatic logic [FN-1:0] rnd_f();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return FN'(x % 64'(Q));
    endfunction

    function automatic logic [FN-1:0] model4();
        return mle_ref(tau4, vals4, 4);
    endfunction

    function automatic logic [FN-1:0] model1();
        logic [FN-1:0] t [NB];
        logic [FN-1:0] v [NV];
        for (int i = 0; i < int'(NB); i++) t[i] = '0;
        for (int i = 0; i < int'(NV); i++) v[i] = '0;
        t[0] = tau1[0];
        v[0] = vals1[0];
        v[1] = vals1[1];
        return mle_ref(t, v, 1);
    endfunction

    task automatic randomize4();
        for (int i = 0; i < int'(NB); i++) tau4[i] = rnd_f();
        for (int i = 0; i < int'(NV); i++) vals4[i] = rnd_f();
    endtask

    // Called just after a posedge: en is sampled at the next edge, result due 15 edges later.
    task automatic start4(input logic [FN-1:0] e);
        en4 = 1'b1;
        q4.push_back('{val: e, due: cyc + 16});
        @(posedge clk); #1;
        en4 = 1'b0;
    endtask

    task automatic start1(input logic [FN-1:0] e);
        en1 = 1'b1;
        q1.push_back('{val: e, due: cyc + 2});
        @(posedge clk); #1;
        en1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain4", 64'(q4.size()), 64'd0);
        check("drain1", 64'(q1.size()), 64'd0);
    endtask

    // Monitors: a rising ready marks a completion; compare value and completion edge.
    always @(negedge clk) begin
        if (rst) begin
            prev4 <= 1'b1;
        end else begin
            if (rdy4 === 1'b1 && prev4 === 1'b0) begin
                if (q4.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra4: unexpected result %0d, none expected", out4);
                end else begin
                    check("res4", 64'(out4), 64'(q4[0].val));
                    check("lat4", 64'(cyc), 64'(q4[0].due));
                    void'(q4.pop_front());
                end
            end
            prev4 <= rdy4;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev1 <= 1'b1;
        end else begin
            if (rdy1 === 1'b1 && prev1 === 1'b0) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra1: unexpected result %0d, none expected", out1);
                end else begin
                    check("res1", 64'(out1), 64'(q1[0].val));
                    check("lat1", 64'(cyc), 64'(q1[0].due));
                    void'(q1.pop_front());
                end
            end
            prev1 <= rdy1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FN-1:0] e;
        void'($urandom(32'h5EED_1234));
        for (int i = 0; i < int'(NB); i++) tau4[i] = '0;
        for (int i = 0; i < int'(NV); i++) vals4[i] = FN'(i);
        tau1[0] = '0;
        vals1[0] = '0;
        vals1[1] = '0;

        // Asynchronous reset asserted between clock edges.
        #13 rst = 1'b1;
        #1;
        check("rst_ready4", 64'(rdy4), 64'd1);
        check("rst_out4", 64'(out4), 64'd0);
        check("rst_ready1", 64'(rdy1), 64'd1);
        check("rst_out1", 64'(out1), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corners on the 4-bit table vals[i] = i.
        start4(FN'(0));
        drain();
        for (int i = 0; i < int'(NB); i++) tau4[i] = FN'(1);
        start4(FN'(15));
        drain();
        for (int i = 0; i < int'(NB); i++) tau4[i] = '0;
        tau4[0] = FN'(1);
        start4(FN'(1));
        drain();
        tau4[0] = '0;
        tau4[3] = FN'(1);
        start4(FN'(8));
        drain();

        // Field wrap-around on the 1-bit instance.
        vals1[0] = FN'(0); vals1[1] = FN'(1); tau1[0] = Q - FN'(1);
        start1(Q - FN'(1));
        drain();
        vals1[0] = FN'(5); vals1[1] = FN'(3); tau1[0] = FN'(2);
        start1(FN'(1));
        drain();

        // Latency, busy-time en ignored, input changes after acceptance ignored.
        for (int i = 0; i < int'(NB); i++) tau4[i] = FN'(1);
        for (int i = 0; i < int'(NV); i++) vals4[i] = FN'(i);
        start4(FN'(15));
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            check("busy4", 64'(rdy4), 64'd0);
            if (i == 4) en4 = 1'b1;
            if (i == 5) begin
                en4 = 1'b0;
                randomize4();
            end
        end
        repeat (20) @(posedge clk);
        #1;
        check("idle4", 64'(rdy4), 64'd1);
        check("hold4", 64'(out4), 64'd15);
        check("noq4", 64'(q4.size()), 64'd0);

        // Back-to-back with en held high; inputs change after the first acceptance.
        randomize4();
        en4 = 1'b1;
        q4.push_back('{val: model4(), due: cyc + 16});
        @(posedge clk); #1;
        randomize4();
        q4.push_back('{val: model4(), due: cyc + 31});
        repeat (16) @(posedge clk);
        #1;
        en4 = 1'b0;
        drain();

        // Reset abort mid-fold, then a clean run.
        randomize4();
        start4(model4());
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        q4.delete();
        #1;
        check("abort_ready4", 64'(rdy4), 64'd1);
        check("abort_out4", 64'(out4), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        randomize4();
        start4(model4());
        drain();

        // Random trials against the reference model.
        for (int t = 0; t < 8; t++) begin
            randomize4();
            start4(model4());
            drain();
        end
        for (int t = 0; t < 4; t++) begin
            tau1[0] = rnd_f();
            vals1[0] = rnd_f();
            vals1[1] = rnd_f();
            e = model1();
            start1(e);
            drain();
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
